// File: rtl/mc_controller_if.sv
// Control bus between the multicycle ARM controller and its datapath.
// The controller takes the slave side: it reads the instruction register and
// the ALU flags, and drives every datapath select and write strobe.
interface mc_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic        B;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [2:0]  ALUControl;

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, B,
           RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl
  );

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, B,
           RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM controller: Moore main FSM with registered per-state
// outputs, a condition-flag register, and condition-gated write strobes.
module mc_controller (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  // Raw per-state controls; the write strobes are condition-gated later.
  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       ir_write;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic       alu_src_a;
    logic       byte_ld;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign unused_instr_bits = ^bus.Instr[19:0];

  state_t     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [3:0] flags_q;   // {N,Z,C,V}
  logic       cond_ex;
  logic       no_write;
  logic       flag_w;
  logic       cv_load;

  // Data-processing command field to ALU operation; unknown commands add.
  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100:          return ALU_ADD;
      4'b0010, 4'b1010: return ALU_SUB;
      4'b0000:          return ALU_AND;
      4'b1100:          return ALU_ORR;
      default:          return ALU_ADD;
    endcase
  endfunction

  // Moore output table for the state being entered.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin
        c.next_pc = 1'b1; c.ir_write = 1'b1; c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10; c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
      end
      S_MEMADR: c.alu_src_b = 2'b01;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB:  begin
        c.result_src = 2'b01; c.reg_w = 1'b1; c.byte_ld = f[2];
      end
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      S_EXECR:  c.alu_ctrl = alu_decode(f[4:1]);
      S_EXECI:  begin c.alu_src_b = 2'b01; c.alu_ctrl = alu_decode(f[4:1]); end
      S_ALUWB:  c.reg_w = 1'b1;
      S_BRANCH: begin
        c.alu_src_b = 2'b01; c.result_src = 2'b10; c.branch = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection from the current state and instruction fields.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d unassigned and infers a latch.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Condition check of Cond against the registered {N,Z,C,V} flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // CMP computes flags only; it must never write the register file.
  assign no_write = (op == 2'b00) && (funct[4:1] == 4'b1010);
  assign flag_w   = ((state_q == S_EXECR) || (state_q == S_EXECI)) && funct[0] && cond_ex;
  // Carry and overflow are meaningful only for arithmetic (add/sub) results.
  assign cv_load  = (ctrl_q.alu_ctrl == ALU_ADD) || (ctrl_q.alu_ctrl == ALU_SUB);

  // FSM state, registered Moore outputs and the flags register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH, 6'b0);
      flags_q <= 4'b0000;
    end else begin
      // NOTE: non-blocking updates let every register see the pre-edge values of the others.
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, funct);
      if (flag_w) begin
        flags_q[3:2] <= bus.ALUFlags[3:2];
        if (cv_load) flags_q[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // Strobes are forced low while reset is held so an abandoned instruction writes nothing.
  assign bus.PCWrite    = ~reset & (ctrl_q.next_pc | (ctrl_q.branch & cond_ex));
  assign bus.IRWrite    = ~reset & ctrl_q.ir_write;
  assign bus.RegWrite   = ~reset & ctrl_q.reg_w & cond_ex & ~no_write;
  assign bus.MemWrite   = ~reset & ctrl_q.mem_w & cond_ex;
  assign bus.AdrSrc     = ctrl_q.adr_src;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.B          = ctrl_q.byte_ld;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ResultSrc  = ctrl_q.result_src;
  assign bus.ALUControl = ctrl_q.alu_ctrl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Instr, input, 32 bits: the instruction register; fields used are Cond[31:28], Op[27:26], Funct[25:20] and Rd[15:12].
REQ-004 SHALL have port ALUFlags, input, 4 bits: combinational ALU flags ordered {N,Z,C,V}.
REQ-005 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA and B, 1 bit each.
REQ-006 SHALL have outputs RegSrc, ImmSrc, ALUSrcB and ResultSrc, 2 bits each, and output ALUControl, 3 bits.
REQ-007 Encodings SHALL be:
- AdrSrc: 0=PC, 1=Result.
- ALUSrcA: 0=A, 1=PC.
- ALUSrcB: 00=WriteData, 01=ExtImm, 10=const 4.
- ResultSrc: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUControl: 000 ADD, 001 SUB, 010 AND, 011 ORR.
- B: 1 = byte load.

Function
REQ-008 SHALL implement a Moore main FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-009 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 and NextPC=1, then go to DECODE.
REQ-010 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=ADD and ResultSrc=10 (PC+8), then transition as follows:
- Op=01 -> MEMADR.
- Op=00 with Funct[5]=0 -> EXECR.
- Op=00 with Funct[5]=1 -> EXECI.
- Op=10 -> BRANCH.
- Op=11 -> FETCH.
REQ-011 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01 and ALUControl=ADD, then go to MEMRD if Funct[0]=1, else MEMWR.
REQ-012 MEMRD SHALL drive ResultSrc=00 and AdrSrc=1 and go to MEMWB; MEMWB SHALL drive ResultSrc=01, RegW=1 and B=Funct[2], then go to FETCH.
REQ-013 MEMWR SHALL drive ResultSrc=00, AdrSrc=1 and MemW=1, then go to FETCH.
REQ-014 EXECR SHALL drive ALUSrcA=0 and ALUSrcB=00; EXECI SHALL drive ALUSrcA=0 and ALUSrcB=01; both SHALL go to ALUWB.
REQ-015 ALUWB SHALL drive ResultSrc=00 and RegW=1, then go to FETCH.
REQ-016 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10 and Branch=1, then go to FETCH.
REQ-017 In EXECR/EXECI, ALUControl SHALL be decoded from Funct[4:1]: 0100 ADD, 0010 SUB, 1010 SUB (CMP), 0000 AND, 1100 ORR; any other value SHALL decode to ADD.
REQ-018 ImmSrc SHALL equal Op. RegSrc[0] SHALL be 1 when Op=10. RegSrc[1] SHALL be 1 when Op=01.
REQ-019 A 4-bit flags register SHALL update in EXECR/EXECI only when Funct[0]=1 and CondEx=1:
- NZ are loaded always.
- CV are loaded only for ADD/SUB/CMP.
REQ-020 CondEx SHALL be evaluated combinationally from Cond and the registered flags for EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; Cond=1111 SHALL give CondEx=0.
REQ-021 The final write strobes SHALL be:
- PCWrite = NextPC | (Branch & CondEx).
- RegWrite = RegW & CondEx & ~NoWrite, where NoWrite=1 for CMP.
- MemWrite = MemW & CondEx.
REQ-022 Latency SHALL be: data-processing 4 cycles, LDR/LDRB 5, STR 4, branch 3, Op=11 2 (treated as NOP).
REQ-023 Every FSM output not listed for a state SHALL be 0.

Reset
REQ-024 Asserting reset SHALL, asynchronously, put the FSM in FETCH and clear the flags register to 0000.
REQ-025 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0; reset mid-instruction SHALL abandon that instruction with no write.
REQ-026 On the first rising edge after reset deasserts, the FETCH strobes SHALL take effect.

Verification
REQ-027 Reset pulse in MEMRD -> state FETCH and all strobes 0 during reset; on release, PCWrite=1 and IRWrite=1.
REQ-028 ADD R1,R2,R3 (0xE0821003) -> FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
REQ-029 LDRB (0xE5D21004) -> 5 states; AdrSrc=1 in MEMRD; B=1 and ResultSrc=01 in MEMWB.
REQ-030 CMP giving Z=1 (0xE1510002), then BEQ (0x0A000002) -> flags Z=1, no RegWrite, and PCWrite=1 in BRANCH.
REQ-031 BNE with Z=1 -> PCWrite=0 in BRANCH. STR with Cond=EQ and Z=0 -> MemWrite=0 in MEMWR.
REQ-032 Cond=1111 or Op=11 -> no RegWrite or MemWrite; FSM returns to FETCH.
